// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: pad synchroniser + per-bit debounce filter feeding CoreGPIO GPIO_IN.
// Define GPIO_DEBOUNCE_EDGE_EN to build the registered RISE/FALL pulse outputs.
module gpio_in_debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   CNT_WIDTH       = 16,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic SYSCLK_apb,
    input  logic PRESETN,
    input  logic pad,
    input  logic bypass,
    output logic db,
    output logic rise,
    output logic fall
);
    typedef enum logic {STABLE, COUNTING} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_WIDTH-1:0]   cnt;
    state_t                 state;
    logic                   sync;
    logic                   mismatch;
    logic                   take;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign mismatch = sync ^ db;
    // Terminal count wins over increment, so the counter can never wrap.
    assign take     = bypass | (mismatch & (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)));

    always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
        if (!PRESETN) sync_q <= {SYNC_STAGES{RESET_BIT}};
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end

    always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
        if (!PRESETN) begin
            state <= STABLE;
            cnt   <= '0;
            db    <= RESET_BIT;
        end else if (take) begin
            state <= STABLE;
            cnt   <= '0;
            db    <= sync;
        end else begin
            case (state)
                STABLE: begin
                    if (mismatch) begin
                        state <= COUNTING;
                        cnt   <= CNT_WIDTH'(1);
                    end
                end
                COUNTING: begin
                    if (mismatch) begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end else begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef GPIO_DEBOUNCE_EDGE_EN
    // Pulses are registered alongside db so they line up with the level change.
    always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
        if (!PRESETN) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= take &  sync & ~db;
            fall <= take & ~sync &  db;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
endmodule

module gpio_in_debounce #(
    parameter int                IO_NUM          = 8,
    parameter int                SYNC_STAGES     = 2,
    parameter int                CNT_WIDTH       = 16,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter logic [IO_NUM-1:0] RESET_VAL       = '0
) (
    input  logic              SYSCLK_apb,
    input  logic              PRESETN,
    input  logic [IO_NUM-1:0] PAD_IN,
    input  logic              BYPASS,
    output logic [IO_NUM-1:0] GPIO_IN_DB,
    output logic [IO_NUM-1:0] RISE,
    output logic [IO_NUM-1:0] FALL
);
    generate
        if (IO_NUM < 1 || IO_NUM > 32) begin : g_bad_io_num
            $error("gpio_in_debounce: IO_NUM must be 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("gpio_in_debounce: SYNC_STAGES must be 2..4");
        end
        if (longint'(DEBOUNCE_CYCLES) < longint'(1) ||
            longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_WIDTH) - longint'(1))) begin : g_bad_cycles
            $error("gpio_in_debounce: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
        end
    endgenerate

    for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
        gpio_in_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .CNT_WIDTH      (CNT_WIDTH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VAL[i])
        ) u_bit (
            .SYSCLK_apb(SYSCLK_apb),
            .PRESETN   (PRESETN),
            .pad       (PAD_IN[i]),
            .bypass    (BYPASS),
            .db        (GPIO_IN_DB[i]),
            .rise      (RISE[i]),
            .fall      (FALL[i])
        );
    end
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Randomised + directed bench for gpio_in_debounce against a sliding-window reference model.
`timescale 1ns/1ps
module tb_gpio_in_debounce;
    localparam int         N  = 8;
    localparam int         S  = 2;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h00;
`ifdef GPIO_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       SYSCLK_apb = 1'b0;
    logic       PRESETN    = 1'b0;
    logic       BYPASS     = 1'b0;
    logic [7:0] PAD_IN     = 8'h00;
    logic [7:0] GPIO_IN_DB, RISE, FALL;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 SYSCLK_apb = ~SYSCLK_apb;

    gpio_in_debounce #(
        .IO_NUM(N), .SYNC_STAGES(S), .CNT_WIDTH(16), .DEBOUNCE_CYCLES(D), .RESET_VAL(RV)
    ) dut (
        .SYSCLK_apb(SYSCLK_apb),
        .PRESETN   (PRESETN),
        .PAD_IN    (PAD_IN),
        .BYPASS    (BYPASS),
        .GPIO_IN_DB(GPIO_IN_DB),
        .RISE      (RISE),
        .FALL      (FALL)
    );

    // Reference: a bit accepts its synchronised level once the last D edges all saw
    // that level disagree with the output, with no bypass edge among them.
    logic [7:0] m_db = RV, m_rise = 8'h00, m_fall = 8'h00;
    logic [7:0] padh[$];
    logic [7:0] seenh[$];
    bit         byph[$];

    always @(posedge SYSCLK_apb or negedge PRESETN) begin : model
        logic [7:0] seen, old;
        bit ok;
        if (!PRESETN) begin
            m_db = RV; m_rise = 8'h00; m_fall = 8'h00;
            padh.delete(); seenh.delete(); byph.delete();
        end else begin
            old  = m_db;
            seen = (padh.size() >= S) ? padh[padh.size()-S] : RV;
            seenh.push_back(seen);
            byph.push_back(BYPASS);
            if (BYPASS) m_db = seen;
            else if (seenh.size() >= D) begin
                for (int i = 0; i < N; i++) begin
                    ok = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (byph[byph.size()-1-j] || seenh[seenh.size()-1-j][i] == m_db[i]) ok = 1'b0;
                    if (ok) m_db[i] = seen[i];
                end
            end
            padh.push_back(PAD_IN);
            if (padh.size() > 16) begin
                void'(padh.pop_front()); void'(seenh.pop_front()); void'(byph.pop_front());
            end
            m_rise = EDGE ? (m_db & ~old) : 8'h00;
            m_fall = EDGE ? (~m_db & old) : 8'h00;
        end
    end

    task automatic test_reset();
        logic [7:0] exp_db, exp_r;
        PRESETN = 1'b0; PAD_IN = 8'hFF; BYPASS = 1'b0;
        repeat (3) @(negedge SYSCLK_apb);
        n_checks++;
        if ({GPIO_IN_DB, RISE, FALL} !== 24'h0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected 000000", {GPIO_IN_DB, RISE, FALL});
        end
        PRESETN = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge SYSCLK_apb);
            exp_db = (t >= 6) ? 8'hFF : 8'h00;
            exp_r  = (EDGE && t == 6) ? 8'hFF : 8'h00;
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {exp_db, exp_r, 8'h00}) begin
                n_fail++; $display("FAIL reset_release t=%0d: got %h expected %h", t,
                                   {GPIO_IN_DB, RISE, FALL}, {exp_db, exp_r, 8'h00});
            end
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {m_db, m_rise, m_fall}) begin
                n_fail++; $display("FAIL reset_model t=%0d: got %h expected %h", t,
                                   {GPIO_IN_DB, RISE, FALL}, {m_db, m_rise, m_fall});
            end
        end
    endtask

    task automatic test_clean_step();
        logic [7:0] exp_db, exp_r;
        PAD_IN = 8'h00;
        repeat (10) begin
            @(negedge SYSCLK_apb);
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {m_db, m_rise, m_fall}) begin
                n_fail++; $display("FAIL step_settle: got %h expected %h",
                                   {GPIO_IN_DB, RISE, FALL}, {m_db, m_rise, m_fall});
            end
        end
        PAD_IN[0] = 1'b1;
        for (int t = 0; t <= 7; t++) begin
            @(negedge SYSCLK_apb);
            exp_db = (t >= 5) ? 8'h01 : 8'h00;
            exp_r  = (EDGE && t == 5) ? 8'h01 : 8'h00;
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {exp_db, exp_r, 8'h00}) begin
                n_fail++; $display("FAIL clean_step t=%0d: got %h expected %h", t,
                                   {GPIO_IN_DB, RISE, FALL}, {exp_db, exp_r, 8'h00});
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        logic [7:0] exp_db, exp_r;
        pat = 5'b10101;
        for (int j = 0; j < 5; j++) begin
            PAD_IN[1] = pat[j];
            @(negedge SYSCLK_apb);
            n_checks++;
            if (GPIO_IN_DB !== 8'h01 || RISE[1] !== 1'b0) begin
                n_fail++; $display("FAIL bounce_hold j=%0d: got db=%h rise=%h expected db=01 rise[1]=0",
                                   j, GPIO_IN_DB, RISE);
            end
        end
        for (int t = 1; t <= 7; t++) begin
            @(negedge SYSCLK_apb);
            exp_db = (t >= 5) ? 8'h03 : 8'h01;
            exp_r  = (EDGE && t == 5) ? 8'h02 : 8'h00;
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {exp_db, exp_r, 8'h00}) begin
                n_fail++; $display("FAIL bounce_accept t=%0d: got %h expected %h", t,
                                   {GPIO_IN_DB, RISE, FALL}, {exp_db, exp_r, 8'h00});
            end
        end
    endtask

    task automatic test_glitch();
        PAD_IN[2] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge SYSCLK_apb);
            if (i == 2) PAD_IN[2] = 1'b0;
            n_checks++;
            if (GPIO_IN_DB !== 8'h03 || RISE[2] !== 1'b0) begin
                n_fail++; $display("FAIL glitch i=%0d: got db=%h rise=%h expected db=03 rise[2]=0",
                                   i, GPIO_IN_DB, RISE);
            end
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {m_db, m_rise, m_fall}) begin
                n_fail++; $display("FAIL glitch_model i=%0d: got %h expected %h", i,
                                   {GPIO_IN_DB, RISE, FALL}, {m_db, m_rise, m_fall});
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_db, exp_r, exp_f;
        PAD_IN = 8'hA5; BYPASS = 1'b1;
        for (int t = 0; t <= 5; t++) begin
            @(negedge SYSCLK_apb);
            exp_db = (t >= 2) ? 8'hA5 : 8'h03;
            exp_r  = (EDGE && t == 2) ? 8'hA4 : 8'h00;
            exp_f  = (EDGE && t == 2) ? 8'h02 : 8'h00;
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {exp_db, exp_r, exp_f}) begin
                n_fail++; $display("FAIL bypass t=%0d: got %h expected %h", t,
                                   {GPIO_IN_DB, RISE, FALL}, {exp_db, exp_r, exp_f});
            end
        end
        BYPASS = 1'b0;
        repeat (6) begin
            @(negedge SYSCLK_apb);
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {m_db, m_rise, m_fall}) begin
                n_fail++; $display("FAIL bypass_off: got %h expected %h",
                                   {GPIO_IN_DB, RISE, FALL}, {m_db, m_rise, m_fall});
            end
        end
    endtask

    task automatic test_reset_mid_count();
        PAD_IN = 8'h5A;
        repeat (3) @(negedge SYSCLK_apb);
        PRESETN = 1'b0;
        #1;
        n_checks++;
        if ({GPIO_IN_DB, RISE, FALL} !== 24'h0) begin
            n_fail++; $display("FAIL reset_mid: got %h expected 000000", {GPIO_IN_DB, RISE, FALL});
        end
        @(negedge SYSCLK_apb);
        PRESETN = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge SYSCLK_apb);
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {m_db, m_rise, m_fall}) begin
                n_fail++; $display("FAIL reset_mid_model t=%0d: got %h expected %h", t,
                                   {GPIO_IN_DB, RISE, FALL}, {m_db, m_rise, m_fall});
            end
            if (t == 1) begin
                n_checks++;
                if ({RISE, FALL} !== 16'h0) begin
                    n_fail++; $display("FAIL reset_mid_first: got %h expected 0000", {RISE, FALL});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) PAD_IN[i] = ~PAD_IN[i];
            if ($urandom_range(39) == 0) BYPASS = ~BYPASS;
            @(negedge SYSCLK_apb);
            n_checks++;
            if ({GPIO_IN_DB, RISE, FALL} !== {m_db, m_rise, m_fall}) begin
                n_fail++; $display("FAIL random c=%0d: got %h expected %h", c,
                                   {GPIO_IN_DB, RISE, FALL}, {m_db, m_rise, m_fall});
            end
        end
        BYPASS = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_bypass();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
